// File: rtl/tl_sensor_gen_pkg.sv
// Shared constants for the traffic-light sensor front-end.
// Light encodings match the values the controller's output logic drives.
package tl_sensor_gen_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    // Width of the debounce stable counter; covers DEB_CYCLES up to 15.
    localparam int unsigned DEB_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RISE_CHK = 2'b01,
        OCCUPIED = 2'b10,
        FALL_CHK = 2'b11
    } deb_state_t;

    function automatic logic is_green(input logic [1:0] light);
        return light == GREEN;
    endfunction

endpackage

// File: rtl/tl_det_channel.sv
// One detector channel: 2-flop synchronizer, debounce FSM, vehicle queue counter,
// sticky overflow flag and registered traffic-present output.
// TL_SENSOR_HOLD_EN: traffic also held high while the loop is occupied.
module tl_det_channel
    import tl_sensor_gen_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned CNT_MAX    = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             det,
    input  logic [1:0]       light,
    input  logic             tick,
    output logic             traffic,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] STAB_ONE = DEB_W'(1);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync2_q;
    deb_state_t       state_q, state_d;
    logic [DEB_W-1:0] stab_q, stab_d;
    logic             arrival;
    logic             depart;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             traffic_q, traffic_d;
    logic             occupied_next;

    // Two-flop synchronizer for the asynchronous detector pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= det;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next-state: a level change is accepted after DEB_CYCLES equal samples.
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        arrival = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = RISE_CHK;
                    stab_d  = STAB_ONE;
                end
            end
            RISE_CHK: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    stab_d  = '0;
                end else if (stab_q == DEB_LAST) begin
                    state_d = OCCUPIED;
                    stab_d  = '0;
                    arrival = 1'b1;
                end else begin
                    stab_d = stab_q + STAB_ONE;
                end
            end
            OCCUPIED: begin
                if (!sync2_q) begin
                    state_d = FALL_CHK;
                    stab_d  = STAB_ONE;
                end
            end
            FALL_CHK: begin
                if (sync2_q) begin
                    // Vehicle still present: no new arrival.
                    state_d = OCCUPIED;
                    stab_d  = '0;
                end else if (stab_q == DEB_LAST) begin
                    state_d = IDLE;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + STAB_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                stab_d  = '0;
            end
        endcase
    end

    // Debounce state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            stab_q  <= '0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
        end
    end

    // Queue update: simultaneous arrival and departure cancel out.
    always_comb begin
        depart = tick && is_green(light) && (cnt_q != '0);
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (arrival && !depart) begin
            if (cnt_q < CNT_TOP) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (depart && !arrival) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        occupied_next = (state_d == OCCUPIED) || (state_d == FALL_CHK);
`ifdef TL_SENSOR_HOLD_EN
        traffic_d = (cnt_d != '0) || occupied_next;
`else
        traffic_d = (cnt_d != '0);
`endif
    end

    // Queue, overflow and traffic registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            traffic_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            traffic_q <= traffic_d;
        end
    end

`ifndef TL_SENSOR_HOLD_EN
    // Occupancy only feeds the hold option.
    logic unused_occ;
    assign unused_occ = occupied_next;
`endif

    assign traffic = traffic_q;
    assign cnt     = cnt_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/tl_sensor_gen.sv
// Sensor front-end for the traffic light controller: two independent detector
// channels producing Ta/Tb. Build option TL_SENSOR_HOLD_EN keeps Tx high while
// a vehicle sits on the loop.
module tl_sensor_gen
    import tl_sensor_gen_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned CNT_MAX    = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             det_a,
    input  logic             det_b,
    input  logic [1:0]       La,
    input  logic [1:0]       Lb,
    input  logic             tick,
    output logic             Ta,
    output logic             Tb,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             ovf_a,
    output logic             ovf_b
);

    tl_det_channel #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W),
        .CNT_MAX    (CNT_MAX)
    ) u_chan_a (
        .clk     (clk),
        .reset_n (reset_n),
        .det     (det_a),
        .light   (La),
        .tick    (tick),
        .traffic (Ta),
        .cnt     (cnt_a),
        .ovf     (ovf_a)
    );

    tl_det_channel #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W),
        .CNT_MAX    (CNT_MAX)
    ) u_chan_b (
        .clk     (clk),
        .reset_n (reset_n),
        .det     (det_b),
        .light   (Lb),
        .tick    (tick),
        .traffic (Tb),
        .cnt     (cnt_b),
        .ovf     (ovf_b)
    );

endmodule

// File: tb/tb_tl_sensor_gen.sv
// Self-checking bench for tl_sensor_gen: directed scenarios plus a random phase,
// all compared every cycle against a run-length reference model.
module tb_tl_sensor_gen;

    localparam int DEB  = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          det_a, det_b, tick;
    logic [1:0]    la, lb;
    logic          ta, tb;
    logic [CW-1:0] cnt_a, cnt_b;
    logic          ovf_a, ovf_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state per channel (0 = A, 1 = B).
    int m_s1[2], m_s2[2], m_lvl[2], m_run[2], m_cnt[2], m_ovf[2], m_t[2];

    always #5 clk = ~clk;

    tl_sensor_gen #(
        .DEB_CYCLES (DEB),
        .CNT_W      (CW),
        .CNT_MAX    (CMAX)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .det_a   (det_a),
        .det_b   (det_b),
        .La      (la),
        .Lb      (lb),
        .tick    (tick),
        .Ta      (ta),
        .Tb      (tb),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b),
        .ovf_a   (ovf_a),
        .ovf_b   (ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0;
            m_cnt[c] = 0; m_ovf[c] = 0; m_t[c] = 0;
        end
    endtask

    // A level is accepted once DEB consecutive synchronized samples differ from it.
    task automatic model_chan(input int c, input logic det, input logic [1:0] lt);
        int arr;
        int dep;
        arr = 0;
        if (m_s2[c] != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == DEB) begin
                m_lvl[c] = m_s2[c];
                m_run[c] = 0;
                arr      = m_lvl[c];
            end
        end else begin
            m_run[c] = 0;
        end
        dep = (tick === 1'b1 && lt == L_GREEN && m_cnt[c] != 0) ? 1 : 0;
        if (arr == 1 && dep == 0) begin
            if (m_cnt[c] < CMAX) m_cnt[c]++;
            else m_ovf[c] = 1;
        end else if (dep == 1 && arr == 0) begin
            m_cnt[c]--;
        end
`ifdef TL_SENSOR_HOLD_EN
        m_t[c] = (m_cnt[c] != 0 || m_lvl[c] == 1) ? 1 : 0;
`else
        m_t[c] = (m_cnt[c] != 0) ? 1 : 0;
`endif
        m_s2[c] = m_s1[c];
        m_s1[c] = int'(det);
    endtask

    task automatic step();
        model_chan(0, det_a, la);
        model_chan(1, det_b, lb);
        @(posedge clk);
        #1;
        chk("cnt_a", 32'(cnt_a), m_cnt[0]);
        chk("cnt_b", 32'(cnt_b), m_cnt[1]);
        chk("Ta",    32'(ta),    m_t[0]);
        chk("Tb",    32'(tb),    m_t[1]);
        chk("ovf_a", 32'(ovf_a), m_ovf[0]);
        chk("ovf_b", 32'(ovf_b), m_ovf[1]);
    endtask

    task automatic run(input int n, input logic da, input logic db);
        det_a = da;
        det_b = db;
        repeat (n) step();
    endtask

    // Asynchronous reset between edges; outputs must clear with no clock.
    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk({tag, "_Ta"},    32'(ta),    0);
        chk({tag, "_Tb"},    32'(tb),    0);
        chk({tag, "_cnt_a"}, 32'(cnt_a), 0);
        chk({tag, "_cnt_b"}, 32'(cnt_b), 0);
        chk({tag, "_ovf_a"}, 32'(ovf_a), 0);
        chk({tag, "_ovf_b"}, 32'(ovf_b), 0);
        model_clear();
        det_a = 1'b0;
        det_b = 1'b0;
        tick  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int dur_a, dur_b;
        reset_n = 1'b0;
        det_a = 1'b0; det_b = 1'b0; tick = 1'b0;
        la = L_RED; lb = L_RED;
        model_clear();
        #2;
        async_reset("rst0");

        // Short pulse: 3 synchronized highs then low gives no arrival.
        run(3, 1'b1, 1'b0);
        run(8, 1'b0, 1'b0);
        chk("short_pulse_cnt_a", 32'(cnt_a), 0);

        // Stable high: Ta rises exactly 2 + DEB cycles after the rise.
        run(5, 1'b1, 1'b0);
        chk("ta_before_latency", 32'(ta), 0);
        run(1, 1'b1, 1'b0);
        chk("ta_at_latency", 32'(ta), 1);
        chk("cnt_a_one", 32'(cnt_a), 1);
        run(4, 1'b1, 1'b0);
        chk("cnt_a_single_arrival", 32'(cnt_a), 1);

        // Bounce on B during OCCUPIED with short zero runs.
        run(10, 1'b1, 1'b1);
        run(2, 1'b1, 1'b0);
        run(3, 1'b1, 1'b1);
        run(3, 1'b1, 1'b0);
        run(2, 1'b1, 1'b1);
        run(1, 1'b1, 1'b0);
        run(6, 1'b1, 1'b1);
        chk("bounce_cnt_b", 32'(cnt_b), 1);

        // Second arrival on A, then release the loop.
        run(8, 1'b0, 1'b1);
        run(8, 1'b1, 1'b1);
        run(8, 1'b0, 1'b1);
        chk("cnt_a_two", 32'(cnt_a), 2);

        // Drain gating: ticks under RED do nothing, under GREEN they drain.
        tick = 1'b1;
        la = L_RED;
        run(3, 1'b0, 1'b1);
        chk("red_no_drain", 32'(cnt_a), 2);
        la = L_YELLOW;
        run(1, 1'b0, 1'b1);
        chk("yellow_no_drain", 32'(cnt_a), 2);
        la = L_GREEN;
        run(1, 1'b0, 1'b1);
        chk("drain_first", 32'(cnt_a), 1);
        chk("ta_still_high", 32'(ta), 1);
        run(1, 1'b0, 1'b1);
        chk("drain_second", 32'(cnt_a), 0);
        chk("ta_fell", 32'(ta), 0);
        run(1, 1'b0, 1'b1);
        chk("no_underflow", 32'(cnt_a), 0);
        tick = 1'b0;

        // Simultaneous arrival and departure on B holds the count.
        lb = L_GREEN;
        run(8, 1'b0, 1'b0);
        chk("cnt_b_before_sim", 32'(cnt_b), 1);
        run(5, 1'b0, 1'b1);
        tick = 1'b1;
        run(1, 1'b0, 1'b1);
        tick = 1'b0;
        chk("sim_cnt_b", 32'(cnt_b), 1);
        chk("sim_tb", 32'(tb), 1);
        chk("sim_no_ovf", 32'(ovf_b), 0);
        run(8, 1'b0, 1'b0);

        // Saturation: 16 arrivals on A under RED.
        la = L_RED;
        lb = L_RED;
        for (int i = 0; i < 16; i++) begin
            run(7, 1'b1, 1'b0);
            run(7, 1'b0, 1'b0);
            if (i == 14) begin
                chk("cnt_a_at_max", 32'(cnt_a), 15);
                chk("ovf_a_not_yet", 32'(ovf_a), 0);
            end
        end
        chk("sat_cnt_a", 32'(cnt_a), 15);
        chk("sat_ovf_a", 32'(ovf_a), 1);

        // Random phase with slowly changing detectors.
        dur_a = 0;
        dur_b = 0;
        for (int i = 0; i < 400; i++) begin
            if (dur_a == 0) begin
                det_a = ~det_a;
                dur_a = int'($urandom_range(1, 10));
            end
            if (dur_b == 0) begin
                det_b = ~det_b;
                dur_b = int'($urandom_range(1, 10));
            end
            dur_a--;
            dur_b--;
            la   = 2'($urandom_range(0, 2));
            lb   = 2'($urandom_range(0, 2));
            tick = ($urandom_range(0, 2) == 0);
            step();
        end
        tick = 1'b0;

        // Reset mid-operation with cnt_a=3 and a rise in progress.
        async_reset("rst1");
        la = L_RED;
        lb = L_RED;
        for (int i = 0; i < 3; i++) begin
            run(7, 1'b1, 1'b0);
            run(7, 1'b0, 1'b0);
        end
        chk("cnt_a_three", 32'(cnt_a), 3);
        run(4, 1'b1, 1'b1);
        async_reset("rst2");
        run(10, 1'b0, 1'b0);
        chk("post_reset_cnt_a", 32'(cnt_a), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
